upcoin_hash_sequencer: RTL and testbench
========================================

Name: upcoin_hash_sequencer

Overview:
- Control FSM that sequences the SHA-256 compression datapath (Ch/Maj/SIGMA/sigma round logic, W schedule, H registers) over one or more 512-bit blocks.
- Accepts blocks through a valid/ready handshake and issues per-cycle datapath strobes: init, load, round enable/index, schedule select and H update.
- Presents the finished digest through a valid/ready handshake.
- Sits between the SPI/message front end and the hash core, replacing its ad-hoc load-edge detection.

Parameters:
- ROUNDS, 64, compression rounds per block; legal range 17..64. Values below 64 are for simulation only.
- COUNT_W, 16, width of the block counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  front end offers a block; data is held by the datapath input bus.
- blk_ready  out  1  sequencer can accept a block this cycle.
- blk_first  in  1  qualifies blk_valid: this block starts a new message, so H is reinitialised to the IV.
- blk_last  in  1  qualifies blk_valid: this block is the final block of the message.
- init_h  out  1  datapath loads the IV into H; when asserted together with load_blk, a..h load from the IV.
- load_blk  out  1  datapath captures block words into W[0..15]; a..h are loaded from H.
- round_en  out  1  datapath performs one round this cycle.
- round_idx  out  6  round number t, used for K[t] and W select.
- w_sel  out  1  0 = use message word W[t]; 1 = use the computed schedule word.
- update_h  out  1  datapath performs H[i] <= H[i] + working var.
- hash_valid  out  1  digest on H is final.
- hash_ready  in  1  consumer takes the digest.
- busy  out  1  high in any state other than IDLE.
- seq_err  out  1  one-cycle pulse flagging a protocol violation.
- blk_count  out  COUNT_W  number of blocks compressed in the current message.

Behaviour:
- States: IDLE, ROUND, UPDATE, OUT.
- Reset (reset_n low, applied asynchronously):
  - state goes to IDLE, rnd=0, last_q=0, chain_open=0, blk_count=0.
  - All strobes, hash_valid, busy and seq_err are 0.
  - blk_ready is forced to 0 while reset_n is low.
  - Reset mid-block or mid-OUT abandons the work with no H update.
- IDLE:
  - blk_ready=1.
  - Accept condition is blk_valid & blk_ready. In the accept cycle, combinationally:
    - load_blk=1.
    - init_h = blk_first | ~chain_open.
    - seq_err=1 if ~blk_first & ~chain_open; the block is treated as first.
  - On the accept edge:
    - last_q <= blk_last.
    - chain_open <= ~blk_last.
    - blk_count <= 1 if init_h, otherwise blk_count+1, saturating at all-ones.
    - rnd <= 0; state goes to ROUND.
  - No accept: remain in IDLE with all strobes at 0.
- ROUND:
  - round_en=1, round_idx=rnd, w_sel=(rnd>=16), blk_ready=0.
  - rnd increments each cycle.
  - When rnd==ROUNDS-1, go to UPDATE next cycle.
  - blk_valid is ignored while in ROUND.
- UPDATE:
  - update_h=1 for exactly one cycle.
  - Next state is OUT if last_q, otherwise IDLE.
- OUT:
  - hash_valid=1; it is held, with the digest stable, until hash_ready.
  - On hash_valid & hash_ready, go to IDLE next cycle.
  - blk_ready=0.
  - If hash_ready is already high on entry, OUT lasts one cycle.
- Timing:
  - Block accepted at cycle T: rounds occupy T+1..T+ROUNDS, update at T+ROUNDS+1, hash_valid first high at T+ROUNDS+2 (66 cycles for ROUNDS=64).
  - Non-last blocks return to IDLE at T+ROUNDS+2, giving a minimum spacing of ROUNDS+2 cycles between accepts.
- Simultaneous events:
  - blk_first & blk_last on the same block is a single-block message.
  - blk_first arriving while chain_open=1 restarts the message: H goes to IV, blk_count=1, no seq_err.
- round_idx is 6 bits and never exceeds ROUNDS-1; the counter does not wrap during operation.
- Outputs are decoded combinationally from registered state; no strobe glitches during the accept cycle beyond the terms above.

Decomposition:
- Package upcoin_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, ROUND, UPDATE, OUT}.
  - localparam SCHED_WORDS=16.
  - localparam MAX_ROUNDS=64.
- Sub-module upcoin_round_counter: 6-bit counter with clear/enable inputs, outputs idx and terminal flag at ROUNDS-1, on the same clk/reset_n.

Test Plan:
- Reset, then a single block with blk_first=1 and blk_last=1, hash_ready=1:
  - Accept cycle has load_blk=1, init_h=1.
  - round_en high for 64 cycles with round_idx 0..63; w_sel=0 for idx 0..15 and 1 for 16..63.
  - update_h at T+65, hash_valid at T+66, blk_count=1, then IDLE.
- Two-block message, blocks offered back-to-back:
  - Second block accepted at T+66 with init_h=0.
  - hash_valid only after the second update; blk_count=2.
- hash_ready held low 10 cycles in OUT:
  - hash_valid and busy stay high, blk_ready=0, and an offered block is not accepted.
  - Release hash_ready, then IDLE next cycle.
- Non-first block after reset:
  - seq_err pulses 1 cycle, init_h=1, blk_count=1.
- reset_n asserted at round 30:
  - All outputs 0 immediately, state IDLE.
  - After release, blk_ready=1 and a new block completes normally.
- ROUNDS=20 build, single block:
  - w_sel rises at idx 16, update_h at T+21, hash_valid at T+22.

Source files
------------

// File: rtl/upcoin_pkg.sv
// rtl/upcoin_pkg.sv - shared types and constants for the SHA-256 block sequencer
package upcoin_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} seq_state_t;

  localparam int SCHED_WORDS = 16;
  localparam int MAX_ROUNDS  = 64;

endpackage

// File: rtl/upcoin_round_counter.sv
// rtl/upcoin_round_counter.sv - round index counter with terminal flag at ROUNDS-1
module upcoin_round_counter #(
  parameter int ROUNDS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] idx_o,
  output logic       last_o
);

  logic [5:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == 6'(ROUNDS - 1));
  assign idx_o  = cnt_q;

  // Holds at ROUNDS-1 instead of wrapping so the index never leaves the legal range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !last_o)
      cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/upcoin_hash_sequencer.sv
// rtl/upcoin_hash_sequencer.sv - control FSM sequencing SHA-256 compression over 512-bit blocks
module upcoin_hash_sequencer
  import upcoin_pkg::*;
#(
  parameter int ROUNDS  = MAX_ROUNDS,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic               blk_first,
  input  logic               blk_last,
  output logic               init_h,
  output logic               load_blk,
  output logic               round_en,
  output logic [5:0]         round_idx,
  output logic               w_sel,
  output logic               update_h,
  output logic               hash_valid,
  input  logic               hash_ready,
  output logic               busy,
  output logic               seq_err,
  output logic [COUNT_W-1:0] blk_count
);

  seq_state_t         state_q, state_d;
  logic               last_q, last_d;
  logic               chain_open_q, chain_open_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               rnd_clr;
  logic [5:0]         rnd_idx;
  logic               rnd_term;

  upcoin_round_counter #(.ROUNDS(ROUNDS)) u_rnd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (rnd_clr),
    .en_i    (round_en),
    .idx_o   (rnd_idx),
    .last_o  (rnd_term)
  );

  assign busy      = (state_q != IDLE);
  assign round_idx = round_en ? rnd_idx : 6'd0;
  assign blk_count = count_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    chain_open_d = chain_open_q;
    count_d      = count_q;
    rnd_clr      = 1'b0;
    blk_ready    = 1'b0;
    load_blk     = 1'b0;
    init_h       = 1'b0;
    seq_err      = 1'b0;
    round_en     = 1'b0;
    w_sel        = 1'b0;
    update_h     = 1'b0;
    hash_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        blk_ready = reset_n;
        if (blk_valid && reset_n) begin
          // A continuation block with no open message is absorbed as a fresh first block.
          load_blk     = 1'b1;
          init_h       = blk_first | ~chain_open_q;
          seq_err      = ~blk_first & ~chain_open_q;
          rnd_clr      = 1'b1;
          last_d       = blk_last;
          chain_open_d = ~blk_last;
          if (init_h)
            count_d = COUNT_W'(1);
          else if (count_q != '1)
            count_d = count_q + 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        round_en = 1'b1;
        w_sel    = (rnd_idx >= 6'(SCHED_WORDS));
        if (rnd_term)
          state_d = UPDATE;
      end
      UPDATE: begin
        update_h = 1'b1;
        state_d  = last_q ? OUT : IDLE;
      end
      OUT: begin
        hash_valid = 1'b1;
        if (hash_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      chain_open_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      chain_open_q <= chain_open_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_upcoin_hash_sequencer.sv
// tb/tb_upcoin_hash_sequencer.sv - randomized self-checking bench against a block-level timing model
module tb_upcoin_hash_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic blk_valid = 1'b0;
  logic blk_first = 1'b0;
  logic blk_last = 1'b0;
  logic hash_ready = 1'b0;

  always #5 clk = ~clk;

  logic        a_rdy, a_init, a_load, a_ren, a_wsel, a_upd, a_hv, a_busy, a_err;
  logic [5:0]  a_idx;
  logic [15:0] a_cnt;
  logic        b_rdy, b_init, b_load, b_ren, b_wsel, b_upd, b_hv, b_busy, b_err;
  logic [5:0]  b_idx;
  logic [1:0]  b_cnt;

  upcoin_hash_sequencer #(.ROUNDS(64), .COUNT_W(16)) dut64 (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(a_rdy),
    .blk_first(blk_first), .blk_last(blk_last), .init_h(a_init), .load_blk(a_load),
    .round_en(a_ren), .round_idx(a_idx), .w_sel(a_wsel), .update_h(a_upd),
    .hash_valid(a_hv), .hash_ready(hash_ready), .busy(a_busy), .seq_err(a_err),
    .blk_count(a_cnt)
  );

  upcoin_hash_sequencer #(.ROUNDS(20), .COUNT_W(2)) dut20 (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(b_rdy),
    .blk_first(blk_first), .blk_last(blk_last), .init_h(b_init), .load_blk(b_load),
    .round_en(b_ren), .round_idx(b_idx), .w_sel(b_wsel), .update_h(b_upd),
    .hash_valid(b_hv), .hash_ready(hash_ready), .busy(b_busy), .seq_err(b_err),
    .blk_count(b_cnt)
  );

  bit sel20 = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int rounds = 64;
  int cmax = 65535;
  bit m_open = 1'b0;
  int m_count = 0;

  wire [14:0] gv64 = {a_load, a_init, a_ren, a_idx, a_wsel, a_upd, a_hv, a_rdy, a_busy, a_err};
  wire [14:0] gv20 = {b_load, b_init, b_ren, b_idx, b_wsel, b_upd, b_hv, b_rdy, b_busy, b_err};
  wire [14:0] gv   = sel20 ? gv20 : gv64;
  wire [15:0] gcnt = sel20 ? {14'd0, b_cnt} : a_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] ev(bit ld, bit ih, bit re, int idx, bit ws, bit up,
                                     bit hv, bit rdy, bit bz, bit er);
    return {ld, ih, re, 6'(idx), ws, up, hv, rdy, bz, er};
  endfunction

  // Entered and left at posedge+1 with this cycle's inputs already driven.
  task automatic step(input string tag, input logic [14:0] e);
    @(negedge clk);
    chk(tag, 32'(gv), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit s);
    reset_n = 1'b0;
    blk_valid = 1'b1;
    hash_ready = 1'b0;
    sel20 = s;
    rounds = s ? 20 : 64;
    cmax = s ? 3 : 65535;
    m_open = 1'b0;
    m_count = 0;
    @(negedge clk);
    chk("reset_outs", 32'(gv), 32'(0));
    chk("reset_cnt", 32'(gcnt), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    blk_valid = 1'b0;
    step("post_reset_idle", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      blk_valid = 1'b0;
      step("idle", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    end
  endtask

  // One block from accept to completion; abort_at >= 0 asserts reset in that round.
  task automatic run_block(input bit first, input bit last, input int hold, input int abort_at);
    bit init, err;
    blk_valid = 1'b1;
    blk_first = first;
    blk_last = last;
    hash_ready = 1'($urandom);
    init = first | ~m_open;
    err = ~first & ~m_open;
    step("accept", ev(1, init, 0, 0, 0, 0, 0, 1, 0, err));
    m_count = init ? 1 : ((m_count >= cmax) ? cmax : m_count + 1);
    m_open = ~last;
    chk("blk_count", 32'(gcnt), 32'(m_count));
    for (int k = 0; k < rounds; k++) begin
      blk_valid = 1'($urandom);
      blk_first = 1'($urandom);
      blk_last = 1'($urandom);
      if (k == abort_at) begin
        blk_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("abort_outs", 32'(gv), 32'(0));
        chk("abort_cnt", 32'(gcnt), 32'(0));
        m_open = 1'b0;
        m_count = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        blk_valid = 1'b0;
        step("abort_idle", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        return;
      end
      step("round", ev(0, 0, 1, k, k >= 16, 0, 0, 0, 1, 0));
    end
    blk_valid = 1'($urandom);
    step("update", ev(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    if (last) begin
      for (int i = 0; i <= hold; i++) begin
        blk_valid = 1'b1;
        hash_ready = (i == hold);
        step("out", ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        chk("out_cnt", 32'(gcnt), 32'(m_count));
      end
    end
  endtask

  initial begin
    do_reset(1'b0);
    run_block(1'b1, 1'b1, 0, -1);
    idle(1);
    run_block(1'b1, 1'b0, 0, -1);
    run_block(1'b0, 1'b1, 0, -1);
    idle(1);
    run_block(1'b1, 1'b1, 10, -1);
    idle(1);

    do_reset(1'b0);
    run_block(1'b0, 1'b1, 1, -1);
    run_block(1'b1, 1'b0, 0, 30);
    run_block(1'b1, 1'b1, 2, -1);

    for (int n = 0; n < 20; n++) begin
      run_block($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4), -1);
      idle($urandom_range(0, 2));
    end

    do_reset(1'b1);
    run_block(1'b1, 1'b1, 0, -1);
    run_block(1'b1, 1'b0, 0, -1);
    for (int n = 0; n < 4; n++)
      run_block(1'b0, 1'b0, 0, -1);
    run_block(1'b0, 1'b1, 1, -1);
    for (int n = 0; n < 8; n++) begin
      run_block($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3), -1);
      idle($urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
